// File: rtl/pcx_bridge_pkg.sv
// Shared definitions for the multi-core PCX-to-stream bridge.
//   - FSM state encodings (IDLE, HDR, DATA, GRANT)
//   - header word field offsets and widths
//   - default PCX request vector width
//   - num_data_words(): stream words needed to carry one PCX packet
package pcx_bridge_pkg;

    // Serialiser FSM states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HDR   = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_GRANT = 2'd3;

    // Default PCX request/grant vector width per core
    localparam int unsigned PCX_REQ_W = 5;

    // Header word layout; every bit not listed here is zero
    localparam int unsigned HDR_CORE_LSB = 0;
    localparam int unsigned HDR_CORE_W   = 4;
    localparam int unsigned HDR_ATOM_BIT = 4;
    localparam int unsigned HDR_REQ_LSB  = 5;

    // Data words per frame: ceil(pcx_w / out_w)
    function automatic int unsigned num_data_words(input int unsigned pcx_w,
                                                   input int unsigned out_w);
        return (pcx_w + out_w - 1) / out_w;
    endfunction

endpackage

// File: rtl/pcx_req_buf.sv
// Per-core 2-entry PCX request FIFO.
// A request reserves a slot in the cycle it is seen ({req, atom} stored); the
// packet data arrives one cycle later and is written into that same slot.
// Occupancy counts reservations, so a slot is held while its data is pending.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req, atom       request vector and atomic flag (req == 0 means no request)
//   data            packet data, valid the cycle after a reservation
//   pop             drop the head entry (issued when its frame is granted)
//   eligible        head entry has (or is this cycle receiving) its data
//   not_empty       at least one reservation held
//   head_req/atom/data  contents of the head entry
//   overflow        sticky: a reservation was refused because the FIFO was full
module pcx_req_buf #(
    parameter int unsigned PCX_WIDTH = 124,
    parameter int unsigned REQ_W     = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REQ_W-1:0]     req,
    input  logic                 atom,
    input  logic [PCX_WIDTH-1:0] data,
    input  logic                 pop,
    output logic                 eligible,
    output logic                 not_empty,
    output logic [REQ_W-1:0]     head_req,
    output logic                 head_atom,
    output logic [PCX_WIDTH-1:0] head_data,
    output logic                 overflow
);

    logic [REQ_W-1:0]     req_mem_q  [2];
    logic [PCX_WIDTH-1:0] data_mem_q [2];
    logic [1:0]           atom_mem_q;
    logic [1:0]           written_q;
    logic                 wr_ptr_q, rd_ptr_q;
    logic [1:0]           count_q, count_d;
    logic                 pend_q, pend_slot_q;
    logic                 ovf_q;
    logic                 reserve, accept, drop;

    assign reserve = |req;
    // A full FIFO still accepts when its head leaves in the same cycle
    assign accept  = reserve && ((count_q != 2'd2) || pop);
    assign drop    = reserve && !accept;
    assign count_d = count_q + {1'b0, accept} - {1'b0, pop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 2; s++) begin
                req_mem_q[s]  <= '0;
                data_mem_q[s] <= '0;
            end
            atom_mem_q  <= '0;
            written_q   <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            pend_q      <= 1'b0;
            pend_slot_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            if (accept) begin
                req_mem_q[wr_ptr_q]  <= req;
                atom_mem_q[wr_ptr_q] <= atom;
                written_q[wr_ptr_q]  <= 1'b0;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            // Data phase of the reservation made last cycle
            if (pend_q) begin
                data_mem_q[pend_slot_q] <= data;
                written_q[pend_slot_q]  <= 1'b1;
            end
            pend_q      <= accept;
            pend_slot_q <= wr_ptr_q;
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // The data-phase bypass lets the arbiter pick the entry in the same cycle its
    // data lands; the serialiser only reads head_data later, after the write.
    assign eligible  = (count_q != 2'd0) &&
                       (written_q[rd_ptr_q] || (pend_q && (pend_slot_q == rd_ptr_q)));
    assign not_empty = (count_q != 2'd0);
    assign head_req  = req_mem_q[rd_ptr_q];
    assign head_atom = atom_mem_q[rd_ptr_q];
    assign head_data = data_mem_q[rd_ptr_q];
    assign overflow  = ovf_q;

endmodule

// File: rtl/pcx_mc_stream_bridge.sv
// Multi-core PCX-to-stream bridge.
// Buffers up to two PCX requests per core, arbitrates round-robin (an atomic
// request locks arbitration to its core until that core's next packet has been
// sent), serialises each packet as a header word plus LSW-first data words onto
// a stall-controlled stream, and pulses the core's PCX grant once the frame left.
// Ports:
//   gclk, reset_l      clock, asynchronous active-low reset
//   spc_pcx_req_pq     per-core request vectors, core i at [i*REQ_W +: REQ_W]
//   spc_pcx_atom_pq    per-core atomic flags, same cycle as the request
//   spc_pcx_data_pa    per-core packets, one cycle after the request
//   pcx_spc_grant_px   per-core grant pulse (the stored request vector)
//   pcx_valid/pcx_stall/pcx_data   output stream
//   busy               frame in flight or any buffer holding a request
//   overflow_err       sticky per-core overflow flags
module pcx_mc_stream_bridge
    import pcx_bridge_pkg::*;
#(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned PCX_WIDTH = 124,
    parameter int unsigned OUT_WIDTH = 32,
    parameter int unsigned REQ_W     = PCX_REQ_W
) (
    input  logic                           gclk,
    input  logic                           reset_l,
    input  logic [NUM_CORES*REQ_W-1:0]     spc_pcx_req_pq,
    input  logic [NUM_CORES-1:0]           spc_pcx_atom_pq,
    input  logic [NUM_CORES*PCX_WIDTH-1:0] spc_pcx_data_pa,
    output logic [NUM_CORES*REQ_W-1:0]     pcx_spc_grant_px,
    output logic                           pcx_valid,
    input  logic                           pcx_stall,
    output logic [OUT_WIDTH-1:0]           pcx_data,
    output logic                           busy,
    output logic [NUM_CORES-1:0]           overflow_err
);

    localparam int unsigned D      = num_data_words(PCX_WIDTH, OUT_WIDTH);
    localparam int unsigned CNT_W  = (D > 1) ? $clog2(D) : 1;
    localparam int unsigned CORE_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int unsigned PAD_W  = D * OUT_WIDTH;

    logic [NUM_CORES-1:0] eligible, not_empty, pop, head_atom;
    logic [REQ_W-1:0]     head_req  [NUM_CORES];
    logic [PCX_WIDTH-1:0] head_data [NUM_CORES];

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CORE_W-1:0] cur_core_q, cur_core_d;
    logic [CORE_W-1:0] rr_ptr_q, rr_ptr_d;
    logic              lock_q, lock_d;
    logic [CORE_W-1:0] lock_core_q, lock_core_d;

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_buf
        pcx_req_buf #(
            .PCX_WIDTH (PCX_WIDTH),
            .REQ_W     (REQ_W)
        ) u_buf (
            .clk       (gclk),
            .rst_n     (reset_l),
            .req       (spc_pcx_req_pq[i*REQ_W +: REQ_W]),
            .atom      (spc_pcx_atom_pq[i]),
            .data      (spc_pcx_data_pa[i*PCX_WIDTH +: PCX_WIDTH]),
            .pop       (pop[i]),
            .eligible  (eligible[i]),
            .not_empty (not_empty[i]),
            .head_req  (head_req[i]),
            .head_atom (head_atom[i]),
            .head_data (head_data[i]),
            .overflow  (overflow_err[i])
        );
        assign pop[i] = (state_q == ST_GRANT) && (cur_core_q == CORE_W'(i));
    end

    // Arbitration: the locked core only, else first eligible at/after the pointer
    logic              found;
    logic [CORE_W-1:0] pick;
    logic [CORE_W-1:0] idx;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        if (lock_q) begin
            found = eligible[lock_core_q];
            pick  = lock_core_q;
        end else begin
            for (int k = 0; k < int'(NUM_CORES); k++) begin
                idx = CORE_W'((int'(rr_ptr_q) + k) % int'(NUM_CORES));
                if (!found && eligible[idx]) begin
                    found = 1'b1;
                    pick  = idx;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cur_core_d  = cur_core_q;
        rr_ptr_d    = rr_ptr_q;
        lock_d      = lock_q;
        lock_core_d = lock_core_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d    = ST_HDR;
                    cur_core_d = pick;
                    rr_ptr_d   = (pick == CORE_W'(NUM_CORES - 1)) ? '0 : pick + CORE_W'(1);
                end
            end
            ST_HDR: begin
                if (!pcx_stall) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end
            end
            ST_DATA: begin
                if (!pcx_stall) begin
                    if (cnt_q == CNT_W'(D - 1)) begin
                        state_d = ST_GRANT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_GRANT: begin
                state_d     = ST_IDLE;
                // Atomic packet keeps arbitration on this core for its partner
                lock_d      = head_atom[cur_core_q];
                lock_core_d = cur_core_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge gclk or negedge reset_l) begin
        if (!reset_l) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cur_core_q  <= '0;
            rr_ptr_q    <= '0;
            lock_q      <= 1'b0;
            lock_core_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_core_q  <= cur_core_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_q      <= lock_d;
            lock_core_q <= lock_core_d;
        end
    end

    // Serialiser datapath; the head entry stays put until GRANT pops it
    logic [REQ_W-1:0]     cur_req;
    logic                 cur_atom;
    logic [PAD_W-1:0]     padded;
    logic [OUT_WIDTH-1:0] hdr_word, data_word;

    assign cur_req  = head_req[cur_core_q];
    assign cur_atom = head_atom[cur_core_q];

    always_comb begin
        hdr_word = '0;
        hdr_word[HDR_CORE_LSB +: HDR_CORE_W] = HDR_CORE_W'(cur_core_q);
        hdr_word[HDR_ATOM_BIT]               = cur_atom;
        hdr_word[HDR_REQ_LSB +: REQ_W]       = cur_req;
    end

    always_comb begin
        padded                  = '0;
        padded[PCX_WIDTH-1:0]   = head_data[cur_core_q];
        data_word               = padded[cnt_q*OUT_WIDTH +: OUT_WIDTH];
    end

    always_comb begin
        case (state_q)
            ST_HDR:  pcx_data = hdr_word;
            ST_DATA: pcx_data = data_word;
            default: pcx_data = '0;
        endcase
    end

    always_comb begin
        pcx_spc_grant_px = '0;
        if (state_q == ST_GRANT) begin
            pcx_spc_grant_px[cur_core_q*REQ_W +: REQ_W] = cur_req;
        end
    end

    assign pcx_valid = ((state_q == ST_HDR) || (state_q == ST_DATA)) && !pcx_stall;
    assign busy      = (state_q != ST_IDLE) || (|not_empty);

endmodule

// File: tb/tb_pcx_mc_stream_bridge.sv
`timescale 1ns/1ps
module tb_pcx_mc_stream_bridge;

    localparam int NC = 4;
    localparam int PW = 124;
    localparam int OW = 32;
    localparam int RW = 5;

    logic              gclk = 1'b0;
    logic              reset_l;
    logic [NC*RW-1:0]  req;
    logic [NC-1:0]     atom;
    logic [NC*PW-1:0]  data;
    logic [NC*RW-1:0]  grant;
    logic              pcx_valid;
    logic              pcx_stall;
    logic [OW-1:0]     pcx_data;
    logic              busy;
    logic [NC-1:0]     ovf;

    int n_checks = 0;
    int n_fail   = 0;

    pcx_mc_stream_bridge #(
        .NUM_CORES (NC),
        .PCX_WIDTH (PW),
        .OUT_WIDTH (OW),
        .REQ_W     (RW)
    ) dut (
        .gclk             (gclk),
        .reset_l          (reset_l),
        .spc_pcx_req_pq   (req),
        .spc_pcx_atom_pq  (atom),
        .spc_pcx_data_pa  (data),
        .pcx_spc_grant_px (grant),
        .pcx_valid        (pcx_valid),
        .pcx_stall        (pcx_stall),
        .pcx_data         (pcx_data),
        .busy             (busy),
        .overflow_err     (ovf)
    );

    always #5 gclk = ~gclk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Move to just after the next rising edge; inputs are driven here
    task automatic cyc();
        @(posedge gclk);
        #1;
    endtask

    task automatic set_req(input int core, input logic [RW-1:0] r, input logic a);
        req[core*RW +: RW] = r;
        atom[core]         = a;
    endtask

    task automatic set_data(input int core, input logic [PW-1:0] d);
        data[core*PW +: PW] = d;
    endtask

    task automatic clr_req();
        req  = '0;
        atom = '0;
    endtask

    task automatic do_reset();
        reset_l   = 1'b0;
        clr_req();
        data      = '0;
        pcx_stall = 1'b0;
        cyc();
        cyc();
        #1;
        chk("reset_outputs", {pcx_valid, pcx_data, grant, busy, ovf}, '0);
        reset_l = 1'b1;
    endtask

    // Receive one frame (no stall), starting the search in the current cycle.
    // Ends in the GRANT cycle.
    task automatic recv_frame(input string tag, input int core, input logic [RW-1:0] r,
                              input logic a, input logic [PW-1:0] d);
        logic [OW-1:0]    exp_hdr;
        logic [127:0]     padded;
        logic [NC*RW-1:0] expg;
        logic             found;
        exp_hdr       = '0;
        exp_hdr[3:0]  = 4'(core);
        exp_hdr[4]    = a;
        exp_hdr[9:5]  = r;
        padded        = {4'h0, d};
        expg          = '0;
        expg[core*RW +: RW] = r;
        found = 1'b0;
        #1;
        for (int i = 0; i < 40; i++) begin
            if (pcx_valid) begin
                found = 1'b1;
                break;
            end
            cyc();
            #1;
        end
        chk({tag, "_frame_seen"}, found, 1'b1);
        if (!found) return;
        chk({tag, "_hdr"}, pcx_data, exp_hdr);
        for (int k = 0; k < 4; k++) begin
            cyc();
            #1;
            chk($sformatf("%s_w%0d", tag, k), {pcx_valid, pcx_data}, {1'b1, padded[k*32 +: 32]});
        end
        cyc();
        #1;
        chk({tag, "_grant"}, {pcx_valid, grant}, {1'b0, expg});
    endtask

    localparam logic [PW-1:0] D0 = 124'h0123_4567_89AB_CDEF_FEDC_BA98_7654_321;
    localparam logic [PW-1:0] F0 = 124'hF00_0000_0000_0000_0000_0000_0000_0001;
    localparam logic [PW-1:0] F1 = 124'h111_1111_2222_2222_3333_3333_4444_4444;
    localparam logic [PW-1:0] F2 = 124'hABC_DEF0_1234_5678_9ABC_DEF0_1357_9BDF;
    localparam logic [PW-1:0] F3 = 124'h5A5_A5A5_A5A5_A5A5_C3C3_C3C3_0F0F_0F0F;

    bit seen_extra;

    initial begin
        reset_l   = 1'b0;
        req       = '0;
        atom      = '0;
        data      = '0;
        pcx_stall = 1'b0;

        // ---------------- single request, exact latency ----------------
        do_reset();
        cyc(); set_req(0, 5'b00001, 1'b0); #1;
        chk("single_t0_valid", pcx_valid, 1'b0);
        cyc(); clr_req(); set_data(0, D0); #1;
        chk("single_t1_idle", {pcx_valid, busy}, 2'b01);
        cyc(); #1; chk("single_hdr", {pcx_valid, pcx_data}, {1'b1, 32'h0000_0020});
        cyc(); #1; chk("single_w0", {pcx_valid, pcx_data}, {1'b1, 32'h8765_4321});
        cyc(); #1; chk("single_w1", {pcx_valid, pcx_data}, {1'b1, 32'hFFED_CBA9});
        cyc(); #1; chk("single_w2", {pcx_valid, pcx_data}, {1'b1, 32'h789A_BCDE});
        cyc(); #1; chk("single_w3", {pcx_valid, pcx_data}, {1'b1, 32'h0012_3456});
        cyc(); #1; chk("single_grant", {pcx_valid, grant}, {1'b0, 20'h00001});
        cyc(); #1; chk("single_after", {grant, busy}, '0);

        // ---------------- round robin ----------------
        do_reset();
        cyc(); set_req(0, 5'b00001, 1'b0); set_req(1, 5'b00010, 1'b0);
               set_req(2, 5'b00100, 1'b0);
        cyc(); clr_req(); set_data(0, F0); set_data(1, F1); set_data(2, F2);
        recv_frame("rr_c0", 0, 5'b00001, 1'b0, F0);
        cyc(); set_req(0, 5'b10000, 1'b0);
        cyc(); clr_req(); set_data(0, F3);
        recv_frame("rr_c1", 1, 5'b00010, 1'b0, F1);
        recv_frame("rr_c2", 2, 5'b00100, 1'b0, F2);
        recv_frame("rr_c0b", 0, 5'b10000, 1'b0, F3);

        // ---------------- atomic pair ----------------
        do_reset();
        cyc(); set_req(1, 5'b00001, 1'b1);
        cyc(); set_req(1, 5'b00010, 1'b0); set_req(3, 5'b00100, 1'b0); set_data(1, F1);
        cyc(); clr_req(); set_data(1, F2); set_data(3, F3);
        recv_frame("atom_c1a", 1, 5'b00001, 1'b1, F1);
        recv_frame("atom_c1b", 1, 5'b00010, 1'b0, F2);
        recv_frame("atom_c3", 3, 5'b00100, 1'b0, F3);

        // ---------------- stall mid-frame ----------------
        do_reset();
        cyc(); set_req(0, 5'b00001, 1'b0);
        cyc(); clr_req(); set_data(0, D0);
        cyc(); #1; chk("stall_hdr", {pcx_valid, pcx_data}, {1'b1, 32'h0000_0020});
        cyc(); #1; chk("stall_w0", {pcx_valid, pcx_data}, {1'b1, 32'h8765_4321});
        cyc(); #1; chk("stall_w1", {pcx_valid, pcx_data}, {1'b1, 32'hFFED_CBA9});
        for (int s = 0; s < 3; s++) begin
            cyc(); pcx_stall = 1'b1; #1;
            chk($sformatf("stall_hold%0d", s), {pcx_valid, pcx_data, grant},
                {1'b0, 32'h789A_BCDE, 20'h0});
        end
        cyc(); pcx_stall = 1'b0; #1;
        chk("stall_w2", {pcx_valid, pcx_data}, {1'b1, 32'h789A_BCDE});
        cyc(); #1; chk("stall_w3", {pcx_valid, pcx_data}, {1'b1, 32'h0012_3456});
        cyc(); #1; chk("stall_grant", {pcx_valid, grant}, {1'b0, 20'h00001});

        // ---------------- overflow ----------------
        do_reset();
        cyc(); pcx_stall = 1'b1; set_req(2, 5'b00001, 1'b0);
        cyc(); set_req(2, 5'b00010, 1'b0); set_data(2, F1);
        cyc(); set_req(2, 5'b00100, 1'b0); set_data(2, F2); #1;
        chk("ovf_before", {pcx_valid, ovf}, 5'b0_0000);
        cyc(); clr_req(); set_data(2, F3); #1;
        chk("ovf_set", {busy, ovf}, 5'b1_0100);
        cyc(); pcx_stall = 1'b0;
        recv_frame("ovf_f1", 2, 5'b00001, 1'b0, F1);
        recv_frame("ovf_f2", 2, 5'b00010, 1'b0, F2);
        seen_extra = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc(); #1;
            if (pcx_valid || (grant != '0)) seen_extra = 1'b1;
        end
        chk("ovf_no_third", seen_extra, 1'b0);
        chk("ovf_sticky", {busy, ovf}, 5'b0_0100);

        // ---------------- reset mid-frame ----------------
        // Serve core 1 first so the round-robin pointer sits past core 0
        cyc(); set_req(1, 5'b00001, 1'b0);
        cyc(); clr_req(); set_data(1, F0);
        recv_frame("rst_pre", 1, 5'b00001, 1'b0, F0);
        cyc(); set_req(1, 5'b00010, 1'b0);
        cyc(); clr_req(); set_data(1, F1);
        cyc(); #1; chk("rst_hdr", {pcx_valid, pcx_data}, {1'b1, 32'h0000_0041});
        cyc(); reset_l = 1'b0; #1;
        chk("rst_immediate", {pcx_valid, pcx_data, grant, busy, ovf}, '0);
        for (int i = 0; i < 2; i++) begin
            cyc(); #1;
            chk($sformatf("rst_hold%0d", i), {pcx_valid, grant, busy}, '0);
        end
        reset_l = 1'b1;
        cyc(); set_req(0, 5'b00001, 1'b0); set_req(3, 5'b01000, 1'b0);
        cyc(); clr_req(); set_data(0, F2); set_data(3, F3);
        recv_frame("rst_c0", 0, 5'b00001, 1'b0, F2);
        recv_frame("rst_c3", 3, 5'b01000, 1'b0, F3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
